decode_execute_stage: RTL and testbench
=======================================

Name: decode_execute_stage

Overview:
- Parametrised successor to the fixed decode/execute pipeline register.
- Carries decode control bits (wbs, mm, ALUop, wm, am, ni, wme) and operands srcA/srcB from decode to execute.
- Adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush for bubble insertion, and a saturating back-pressure stall counter.

Parameters:
- DATA_WIDTH, 16, width of srcA/srcB.
- ALUOP_WIDTH, 3, width of the ALU opcode.
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  decode presents a payload.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- wbs_in, mm_in, wm_in, am_in, ni_in, wme_in  in  1 each  control bits.
- aluop_in  in  ALUOP_WIDTH  ALU opcode.
- srca_in, srcb_in  in  DATA_WIDTH  operands.
- out_valid  out  1  main entry holds a payload.
- out_ready  in  1  execute accepts.
- wbs_out, mm_out, wm_out, am_out, ni_out, wme_out  out  1 each  registered control bits.
- aluop_out  out  ALUOP_WIDTH  registered opcode.
- srca_out, srcb_out  out  DATA_WIDTH  registered operands.
- stall_count  out  CNT_WIDTH  cycles with out_valid && !out_ready.

Behaviour:
- Fire rules: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- Storage: main register drives all *_out ports directly. Skid register holds one extra payload.
- States:
  - EMPTY: main and skid invalid.
  - ONE: main valid.
  - FULL: main and skid valid.
- Reset (rst=1, async): state EMPTY; out_valid=0; in_ready=1; every payload output 0; stall_count=0.
- Transitions (flush=0):
  - EMPTY, in_fire -> ONE, main<=in. No fire -> stays EMPTY.
  - ONE, in_fire && out_fire -> ONE, main<=in.
  - ONE, in_fire only -> FULL, skid<=in.
  - ONE, out_fire only -> EMPTY, main payload cleared to 0.
  - ONE, neither -> hold.
  - FULL: in_ready=0, so no in_fire. out_fire -> ONE, main<=skid, skid cleared. No out_fire -> hold.
- Latency: in_fire at edge N gives out_valid=1 with that payload after edge N, when the stage was EMPTY or ONE with out_fire. Zero-bubble throughput at 1 payload/cycle while out_ready=1.
- Ordering: strict FIFO. The skid payload never overtakes main.
- Payload stability: while out_valid && !out_ready, all *_out hold unchanged.
- Empty outputs: when out_valid=0, all payload outputs are 0, which encodes a NOP bubble.
- Flush:
  - Highest priority after rst. At the next edge: state EMPTY, main and skid cleared to 0, in_ready=1.
  - A concurrent in_fire is discarded.
  - A concurrent out_fire counts as consumed by execute.
- stall_count:
  - Increments on each edge where out_valid && !out_ready.
  - Saturates at 2^CNT_WIDTH-1.
  - Unaffected by flush; cleared only by rst.
- Reset mid-operation: rst asserted in any state returns to reset values immediately, without waiting for clk.

Decomposition:
- Shared package pipe_pkg holds:
  - enum skid_state_t {EMPTY, ONE, FULL};
  - struct de_payload_t packing control bits, opcode and operands, sized by package localparams defaulting to 16/3;
  - localparam NOP payload = all zeros.
- One natural sub-module, sat_counter (parameter WIDTH; inputs clk, rst, inc; output count), used for stall_count.
- Skid logic stays in decode_execute_stage.

Test Plan:
- Reset: rst=1 mid-stream -> out_valid=0, in_ready=1, all outputs 0, stall_count=0 without a clk edge.
- Pass-through: out_ready=1, inputs wbs=1, mm=1, aluop=001, wm=1, am=1, ni=1, wme=0, srcA=0x0006, srcB=0x0007 -> next cycle outputs equal those values. Next input aluop=010, srcA=0x0001, srcB=0x0005 appears one cycle later with no bubble.
- Back-pressure: out_ready=0, push A=0x0011 then B=0x0022 -> in_ready=0 after B is accepted, out holds A. Then out_ready=1 -> A then B on consecutive cycles, stall_count=2, in_ready returns to 1.
- Flush in FULL with in_valid=1 and C=0x0033 -> next cycle out_valid=0, payload outputs 0, in_ready=1, C never emerges.
- Saturation: CNT_WIDTH=4, 20 cycles of out_valid=1 and out_ready=0 -> stall_count=15.
- Randomised in_valid/out_ready over 1000 cycles -> output sequence equals input sequence; payload never changes while out_valid && !out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the decode/execute pipeline boundary: skid state and the
// default-width payload layout carried from decode into execute.
package pipe_pkg;

    localparam int PKG_DATA_W  = 16;
    localparam int PKG_ALUOP_W = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic                   wbs;
        logic                   mm;
        logic                   wm;
        logic                   am;
        logic                   ni;
        logic                   wme;
        logic [PKG_ALUOP_W-1:0] aluop;
        logic [PKG_DATA_W-1:0]  srca;
        logic [PKG_DATA_W-1:0]  srcb;
    } de_payload_t;

    // All-zero payload is the NOP bubble seen by execute.
    localparam de_payload_t NOP = '0;

endpackage

// File: rtl/decode_execute_stage_sat_counter.sv
// Saturating up-counter; sticks at all-ones until reset.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/decode_execute_stage.sv
// Decode-to-execute pipeline register with valid/ready handshake, a one-deep
// skid entry behind the main register, synchronous flush and a stall counter.
module decode_execute_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ALUOP_WIDTH = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   wbs_in,
    input  logic                   mm_in,
    input  logic                   wm_in,
    input  logic                   am_in,
    input  logic                   ni_in,
    input  logic                   wme_in,
    input  logic [ALUOP_WIDTH-1:0] aluop_in,
    input  logic [DATA_WIDTH-1:0]  srca_in,
    input  logic [DATA_WIDTH-1:0]  srcb_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   wbs_out,
    output logic                   mm_out,
    output logic                   wm_out,
    output logic                   am_out,
    output logic                   ni_out,
    output logic                   wme_out,
    output logic [ALUOP_WIDTH-1:0] aluop_out,
    output logic [DATA_WIDTH-1:0]  srca_out,
    output logic [DATA_WIDTH-1:0]  srcb_out,
    output logic [CNT_WIDTH-1:0]   stall_count
);

    localparam int PW = 6 + ALUOP_WIDTH + 2 * DATA_WIDTH;

    skid_state_t   r_state;
    skid_state_t   w_state_nxt;
    logic [PW-1:0] r_main;
    logic [PW-1:0] r_skid;
    logic [PW-1:0] w_main_nxt;
    logic [PW-1:0] w_skid_nxt;
    logic [PW-1:0] w_in_pl;
    logic          r_out_valid;
    logic          r_in_ready;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_stall;

    assign w_in_pl    = {wbs_in, mm_in, wm_in, am_in, ni_in, wme_in, aluop_in, srca_in, srcb_in};
    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_stall    = r_out_valid && !out_ready;

    // Any entry that leaves its slot is zeroed, so an empty main register is a NOP.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = '0;
            w_skid_nxt  = '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = w_in_pl;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = w_in_pl;
                    end else if (w_in_fire) begin
                        w_state_nxt = FULL;
                        w_skid_nxt  = w_in_pl;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                        w_main_nxt  = '0;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = '0;
                    w_skid_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_out_valid <= (w_state_nxt != EMPTY);
            r_in_ready  <= (w_state_nxt != FULL);
        end
    end

    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign {wbs_out, mm_out, wm_out, am_out, ni_out, wme_out, aluop_out, srca_out, srcb_out} = r_main;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall),
        .count (stall_count)
    );

endmodule

// File: tb/tb_decode_execute_stage.sv
// Randomised and directed bench for decode_execute_stage against a queue model.
module tb_decode_execute_stage;

    localparam int DW     = 16;
    localparam int AW     = 3;
    localparam int CW     = 4;
    localparam int PW     = 6 + AW + 2 * DW;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] in_pl = '0;

    logic          in_ready, out_valid;
    logic          wbs_in, mm_in, wm_in, am_in, ni_in, wme_in;
    logic [AW-1:0] aluop_in;
    logic [DW-1:0] srca_in, srcb_in;
    logic          wbs_out, mm_out, wm_out, am_out, ni_out, wme_out;
    logic [AW-1:0] aluop_out;
    logic [DW-1:0] srca_out, srcb_out;
    logic [CW-1:0] stall_count;
    logic [PW-1:0] w_obs;

    int n_vec  = 0;
    int n_fail = 0;
    logic [PW-1:0] q[$];
    int exp_cnt = 0;

    always #5 clk = ~clk;

    assign {wbs_in, mm_in, wm_in, am_in, ni_in, wme_in, aluop_in, srca_in, srcb_in} = in_pl;
    assign w_obs = {wbs_out, mm_out, wm_out, am_out, ni_out, wme_out, aluop_out, srca_out, srcb_out};

    decode_execute_stage #(
        .DATA_WIDTH  (DW),
        .ALUOP_WIDTH (AW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .wbs_in      (wbs_in),
        .mm_in       (mm_in),
        .wm_in       (wm_in),
        .am_in       (am_in),
        .ni_in       (ni_in),
        .wme_in      (wme_in),
        .aluop_in    (aluop_in),
        .srca_in     (srca_in),
        .srcb_in     (srcb_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .wbs_out     (wbs_out),
        .mm_out      (mm_out),
        .wm_out      (wm_out),
        .am_out      (am_out),
        .ni_out      (ni_out),
        .wme_out     (wme_out),
        .aluop_out   (aluop_out),
        .srca_out    (srca_out),
        .srcb_out    (srcb_out),
        .stall_count (stall_count)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [PW-1:0] head;
        head = (q.size() > 0) ? q[0] : '0;
        check_val("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check_val("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check_val("payload", 64'(w_obs), 64'(head));
        check_val("stall_count", 64'(stall_count), 64'(exp_cnt));
    endtask

    // Model: the stage is a 2-deep FIFO; flush empties it, stalls are counted.
    task automatic cycle(input logic iv, input logic ordy, input logic fl, input logic [PW-1:0] pl);
        logic          m_in_fire, m_out_fire, hold;
        logic [PW-1:0] prev;
        in_valid   = iv;
        out_ready  = ordy;
        flush      = fl;
        in_pl      = pl;
        m_in_fire  = iv && (q.size() < 2);
        m_out_fire = (q.size() > 0) && ordy;
        hold       = (q.size() > 0) && !ordy && !fl;
        prev       = w_obs;
        if ((q.size() > 0) && !ordy && (exp_cnt < CNTMAX)) exp_cnt++;
        if (fl) begin
            q.delete();
        end else begin
            if (m_out_fire) void'(q.pop_front());
            if (m_in_fire) q.push_back(pl);
        end
        @(posedge clk);
        #1;
        check_model();
        if (hold) check_val("stable", 64'(w_obs), 64'(prev));
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        exp_cnt = 0;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_payload", 64'(w_obs), 64'd0);
        check_val("rst_stall", 64'(stall_count), 64'd0);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] p1, p2, pa, pb, pc, px, py;
        p1 = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 16'h0006, 16'h0007};
        p2 = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 16'h0001, 16'h0005};
        pa = {6'b0, 3'b000, 16'h0011, 16'h0000};
        pb = {6'b0, 3'b000, 16'h0022, 16'h0000};
        pc = {6'b0, 3'b000, 16'h0033, 16'h0000};
        px = {6'b101010, 3'b111, 16'hAAAA, 16'h5555};
        py = {6'b010101, 3'b011, 16'h1234, 16'h8765};

        #12;
        check_val("init_out_valid", 64'(out_valid), 64'd0);
        check_val("init_in_ready", 64'(in_ready), 64'd1);
        check_val("init_payload", 64'(w_obs), 64'd0);
        check_val("init_stall", 64'(stall_count), 64'd0);
        rst = 1'b0;

        // Pass-through with zero bubbles
        cycle(1'b1, 1'b1, 1'b0, p1);
        check_val("pt_first", 64'(w_obs), 64'(p1));
        cycle(1'b1, 1'b1, 1'b0, p2);
        check_val("pt_second", 64'(w_obs), 64'(p2));
        check_val("pt_second_vld", 64'(out_valid), 64'd1);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check_val("pt_drain", 64'(out_valid), 64'd0);

        // Back-pressure into the skid entry
        cycle(1'b1, 1'b0, 1'b0, pa);
        cycle(1'b1, 1'b0, 1'b0, pb);
        check_val("bp_in_ready", 64'(in_ready), 64'd0);
        check_val("bp_hold_a", 64'(w_obs), 64'(pa));
        cycle(1'b0, 1'b0, 1'b0, '0);
        check_val("bp_still_a", 64'(w_obs), 64'(pa));
        cycle(1'b0, 1'b1, 1'b0, '0);
        check_val("bp_then_b", 64'(w_obs), 64'(pb));
        check_val("bp_ready_back", 64'(in_ready), 64'd1);
        check_val("bp_stalls", 64'(stall_count), 64'd2);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check_val("bp_empty", 64'(out_valid), 64'd0);

        // Flush while FULL with a competing input
        cycle(1'b1, 1'b0, 1'b0, px);
        cycle(1'b1, 1'b0, 1'b0, py);
        cycle(1'b1, 1'b0, 1'b1, pc);
        check_val("fl_out_valid", 64'(out_valid), 64'd0);
        check_val("fl_payload", 64'(w_obs), 64'd0);
        check_val("fl_in_ready", 64'(in_ready), 64'd1);
        repeat (3) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
            check_val("fl_no_c", 64'(out_valid), 64'd0);
        end

        // Stall counter saturation
        pulse_reset();
        cycle(1'b1, 1'b0, 1'b0, px);
        repeat (20) cycle(1'b0, 1'b0, 1'b0, '0);
        check_val("sat_count", 64'(stall_count), 64'(CNTMAX));

        // Asynchronous reset in the middle of a stalled stream
        cycle(1'b1, 1'b0, 1'b0, py);
        pulse_reset();

        for (int i = 0; i < 1000; i++) begin
            cycle(($urandom_range(3) != 0), ($urandom_range(2) != 0),
                  ($urandom_range(31) == 0), PW'({$urandom(), $urandom()}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
